// File: rtl/matrix_uart_pkg.sv
// matrix_uart_pkg: shared sizes, defaults and sender states for the UART matrix-multiply path
package matrix_uart_pkg;
    localparam int MAT_DIM = 3;
    localparam int N_ELEM = MAT_DIM * MAT_DIM;
    localparam int ELEM_W_DEFAULT = 24;
    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;
endpackage

// File: rtl/matrix_result_sender.sv
// matrix_result_sender: serialises a 3x3 result matrix into a header/payload/checksum byte frame
module matrix_result_sender
    import matrix_uart_pkg::*;
#(
    parameter int ELEM_W = ELEM_W_DEFAULT,
    parameter logic [7:0] HEADER = HEADER_DEFAULT,
    parameter bit CHECKSUM_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [N_ELEM*ELEM_W-1:0] load_data,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    input  logic                     tx_busy,
    input  logic                     tx_done,
    output logic                     busy,
    output logic                     frame_done
);
    localparam int BPE = ELEM_W / 8;
    localparam int PAY = N_ELEM * BPE;
    localparam int L = 1 + PAY + int'(CHECKSUM_EN);
    localparam int IW = $clog2(L);
    localparam int JW = $clog2(BPE);
    state_t state, next;
    logic [N_ELEM*ELEM_W-1:0] mat;
    logic [IW-1:0] idx;
    logic [3:0] k;
    logic [JW-1:0] j;
    logic [7:0] csum, pay_byte, cur_byte;
    logic fire, advance, last, in_pay, j_wrap;
    assign fire = state == ISSUE && !tx_busy;
    assign advance = state == WAIT && tx_done;
    assign last = idx == IW'(L - 1);
    assign in_pay = idx != '0 && int'(idx) <= PAY;
    assign j_wrap = int'(j) == BPE - 1;
    // (k, j) track element and byte-within-element so no divider is needed
    assign pay_byte = mat[int'(k)*ELEM_W + (BPE-1-int'(j))*8 +: 8];
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= next;
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = load_valid ? ISSUE : IDLE;
            ISSUE:   next = tx_busy ? ISSUE : WAIT;
            WAIT:    next = tx_done ? (last ? FIN : ISSUE) : WAIT;
            default: next = IDLE;
        endcase
    end
    always_comb begin
        load_ready = state == IDLE;
        busy = state != IDLE;
        frame_done = state == FIN;
        cur_byte = idx == '0 ? HEADER : in_pay ? pay_byte : csum;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            mat <= '0;
            idx <= '0;
            k <= '0;
            j <= '0;
            csum <= '0;
            tx_data <= '0;
            tx_start <= 1'b0;
        end else begin
            tx_start <= fire;
            if (state == IDLE && load_valid) begin
                mat <= load_data;
                idx <= '0;
                k <= '0;
                j <= '0;
                csum <= '0;
            end
            if (fire) begin
                tx_data <= cur_byte;
                if (in_pay) csum <= csum ^ pay_byte;
            end
            if (advance && !last) begin
                idx <= idx + 1'b1;
                if (in_pay) begin
                    j <= j_wrap ? '0 : j + 1'b1;
                    if (j_wrap) k <= k + 1'b1;
                end
            end
        end
endmodule

// File: tb/tb_matrix_result_sender.sv
// tb_matrix_result_sender: directed frames checked by a byte scoreboard fed from a transmitter model
module tb_matrix_result_sender;
    import matrix_uart_pkg::*;
    localparam int W = N_ELEM * 24;
    logic clk = 0, rst = 1, load_valid = 0, tx_busy = 0, model_done = 0, spur_done = 0, sel = 0;
    logic [W-1:0] load_data = '0, mat19, matmax, matother;
    logic lr1, ts1, b1, fd1, lr2, ts2, b2, fd2, lr, ts, fd, tx_done;
    logic [7:0] td1, td2, td;
    int checks = 0, errors = 0, nbytes = 0, nstarts = 0, frames = 0, cnt = 0, since_done = 0, exp_len = 29;
    logic prev_start = 0;
    logic [7:0] exp_q[$];

    assign tx_done = model_done | spur_done;
    assign lr = sel ? lr2 : lr1;
    assign ts = sel ? ts2 : ts1;
    assign td = sel ? td2 : td1;
    assign fd = sel ? fd2 : fd1;

    always #5 clk = ~clk;

    matrix_result_sender dut1 (
        .clk(clk), .rst(rst), .load_valid(load_valid & ~sel), .load_ready(lr1), .load_data(load_data),
        .tx_data(td1), .tx_start(ts1), .tx_busy(tx_busy), .tx_done(tx_done & ~sel), .busy(b1), .frame_done(fd1)
    );
    matrix_result_sender #(.CHECKSUM_EN(1'b0)) dut2 (
        .clk(clk), .rst(rst), .load_valid(load_valid & sel), .load_ready(lr2), .load_data(load_data),
        .tx_data(td2), .tx_start(ts2), .tx_busy(tx_busy), .tx_done(tx_done & sel), .busy(b2), .frame_done(fd2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transmitter model and scoreboard monitor: pops one expected byte per tx_start
    always @(negedge clk) begin
        model_done = 0;
        since_done++;
        if (rst) begin
            cnt = 0;
            nbytes = 0;
            prev_start = 0;
        end else begin
            if (cnt != 0) begin
                cnt--;
                if (cnt == 0) begin
                    model_done = 1;
                    since_done = 0;
                end
            end
            if (ts) begin
                chk("start_spacing", 32'(prev_start), 0);
                nstarts++;
                nbytes++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected none", td);
                end else chk("tx_byte", 32'(td), 32'(exp_q.pop_front()));
                cnt = 10;
            end
            prev_start = ts;
            if (fd) begin
                chk("frame_len", nbytes, exp_len);
                chk("done_after_last", since_done, 1);
                chk("queue_empty", exp_q.size(), 0);
                nbytes = 0;
                frames++;
            end
        end
    end

    task automatic push_frame(input logic [W-1:0] d, input bit cs, input logic [7:0] cs_val);
        exp_q.push_back(8'hA5);
        for (int e = 0; e < 9; e++)
            for (int b = 2; b >= 0; b--) exp_q.push_back(d[e*24 + b*8 +: 8]);
        if (cs) exp_q.push_back(cs_val);
        exp_len = cs ? 29 : 28;
    endtask

    task automatic load(input logic [W-1:0] d);
        int n = 0;
        while (!lr && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("load_ready_wait", 32'(lr), 1);
        load_valid = 1;
        load_data = d;
        @(negedge clk);
        load_valid = 0;
    endtask

    task automatic wait_frame(input int target);
        int n = 0;
        while (frames < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_timeout", frames, target);
    endtask

    task automatic wait_bytes(input int target);
        int n = 0;
        while (nbytes < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("byte_timeout", nbytes, target);
    endtask

    initial begin
        int s;
        for (int e = 0; e < 9; e++) begin
            mat19[e*24 +: 24] = 24'(e + 1);
            matmax[e*24 +: 24] = 24'h02FA03;
            matother[e*24 +: 24] = 24'h111111 * 24'(e + 1);
        end
        repeat (3) @(negedge clk);
        chk("rst_load_ready", 32'(lr1), 1);
        chk("rst_tx_start", 32'(ts1), 0);
        chk("rst_tx_data", 32'(td1), 0);
        chk("rst_busy", 32'(b1), 0);
        chk("rst_frame_done", 32'(fd1), 0);
        rst = 0;
        @(negedge clk);
        // basic frame with explicit first-byte latency
        push_frame(mat19, 1, 8'h01);
        load(mat19);
        chk("busy_after_load", 32'(b1), 1);
        @(negedge clk);
        chk("latency_start", 32'(ts1), 1);
        chk("latency_header", 32'(td1), 8'hA5);
        wait_frame(1);
        @(negedge clk);
        chk("idle_after_frame", 32'(lr1), 1);
        chk("busy_after_frame", 32'(b1), 0);
        // maximum element value
        push_frame(matmax, 1, 8'hFB);
        load(matmax);
        wait_frame(2);
        // transmitter busy for 50 cycles after load
        tx_busy = 1;
        push_frame(mat19, 1, 8'h01);
        load(mat19);
        s = nstarts;
        repeat (50) @(negedge clk);
        chk("no_start_while_busy", nstarts, s);
        tx_busy = 0;
        @(negedge clk);
        chk("start_after_busy", 32'(ts1), 1);
        wait_frame(3);
        // spurious tx_done in IDLE and ISSUE, spurious load mid-frame
        push_frame(mat19, 1, 8'h01);
        @(negedge clk);
        spur_done = 1;
        @(negedge clk);
        spur_done = 0;
        tx_busy = 1;
        load(mat19);
        spur_done = 1;
        @(negedge clk);
        spur_done = 0;
        @(negedge clk);
        tx_busy = 0;
        wait_bytes(5);
        load_valid = 1;
        load_data = matother;
        chk("load_ready_midframe", 32'(lr1), 0);
        @(negedge clk);
        load_valid = 0;
        wait_frame(4);
        // reset mid-frame, then a full fresh frame
        push_frame(mat19, 1, 8'h01);
        load(mat19);
        wait_bytes(10);
        @(negedge clk);
        rst = 1;
        #1;
        chk("midrst_tx_start", 32'(ts1), 0);
        chk("midrst_tx_data", 32'(td1), 0);
        chk("midrst_load_ready", 32'(lr1), 1);
        chk("midrst_busy", 32'(b1), 0);
        chk("midrst_frame_done", 32'(fd1), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        push_frame(mat19, 1, 8'h01);
        load(mat19);
        wait_frame(5);
        // checksum disabled instance
        @(negedge clk);
        sel = 1;
        push_frame(mat19, 0, 8'h00);
        load(mat19);
        wait_frame(6);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/matrix_result_sender.md
# matrix_result_sender

Downstream stage of the UART matrix-multiply path. Accepts one completed 3x3 result matrix as a single flattened word and serialises it into a framed byte stream for the UART transmitter. The stream is a header byte, then every element MSB-byte first in row-major order, then an optional XOR checksum. The block also produces the one-cycle `tx_start` pulse and respects the transmitter's busy/done handshake.

## Interface
- `ELEM_W`, 24: result element width in bits; must be a multiple of 8 and ≥ 18, since 3·255·255 = 195075 needs 18 bits.
- `HEADER`, 8'hA5: frame header byte.
- `CHECKSUM_EN`, 1: when 1, append the XOR of all payload bytes as the last byte.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `load_valid` in 1: `load_data` holds a complete result matrix.
- `load_ready` out 1: block is idle and will accept a matrix.
- `load_data` in 9·ELEM_W: element k (row-major, k = 0..8) occupies bits [k·ELEM_W +: ELEM_W].
- `tx_data` out 8: byte for the transmitter.
- `tx_start` out 1: one-cycle start pulse to the transmitter.
- `tx_busy` in 1: transmitter is busy.
- `tx_done` in 1: one-cycle pulse, synchronous to `clk`, meaning the byte is fully sent. The integration layer synchronises it from the baud domain.
- `busy` out 1: a frame is in progress.
- `frame_done` out 1: one-cycle pulse after the last byte's `tx_done`.

## Operation
- **Sizes.** BPE = ELEM_W/8. Payload = 9·BPE bytes. Frame length L = 1 + 9·BPE + CHECKSUM_EN, which is 29 for the defaults.
- **Byte order.**
  - Index 0 is `HEADER`.
  - Index 1 + k·BPE + j carries byte (BPE−1−j) of element k, so each element goes MSB first.
  - Index L−1 is the checksum when `CHECKSUM_EN` = 1.
- **Checksum.** XOR of payload bytes only (header excluded). It is accumulated as each payload byte is issued.
- **States:**
  - **IDLE:**
    - `load_ready` = 1.
    - On `load_valid` && `load_ready`: capture `load_data` into an internal register, clear the byte index and checksum, go to ISSUE.
  - **ISSUE:**
    - Stays here while `tx_busy` = 1.
    - When `tx_busy` = 0: register `tx_data` = byte[index], pulse `tx_start` for one cycle, go to WAIT.
  - **WAIT:**
    - On `tx_done`: if index = L−1, go to FIN; otherwise index++ and go to ISSUE.
  - **FIN:** `frame_done` = 1 for one cycle, then go to IDLE.
- **Input stability.** The captured matrix is held unchanged for the whole frame; changes on `load_data` after capture are ignored.
- **Ignored inputs.**
  - `tx_done` outside WAIT is ignored. A spurious pulse in IDLE or ISSUE does not advance the index.
  - `load_valid` outside IDLE is ignored, with `load_ready` = 0. It is not queued.
- **Reset.** Reset at any point, including mid-frame, returns to IDLE and discards the remaining bytes. No partial checksum is emitted.

## Timing
- **Reset values:** state IDLE, `load_ready` = 1, `tx_start` = 0, `tx_data` = 8'h00, `busy` = 0, `frame_done` = 0, index = 0, checksum = 0.
- **Load to first byte.** Load accepted at clock edge N. With `tx_busy` low, `tx_start` is high during the cycle after edge N+1, with `tx_data` = `HEADER`. Latency is 2 cycles.
- **Data hold.** `tx_data` is stable from the `tx_start` cycle until the next `tx_start`.
- **Pulse spacing.** `tx_start` is never high for two consecutive cycles. There are at least 2 cycles between pulses (the WAIT → ISSUE → start path).
- **`busy`.** High from the cycle after acceptance until `frame_done` is asserted, inclusive.
- **`frame_done`.** Asserted in the cycle after the final `tx_done`.
- **Back-to-back frames.** `load_ready` returns high the cycle after `frame_done`, so a new matrix can be accepted then.
- **Simultaneous events.** `tx_done` arriving in the same cycle that ISSUE fires is impossible by construction, because ISSUE only fires when no byte is outstanding.

## Structure
- **Shared package `matrix_uart_pkg`:**
  - `MAT_DIM` = 3, `N_ELEM` = 9.
  - `HEADER_DEFAULT` = 8'hA5.
  - The state enum {IDLE, ISSUE, WAIT, FIN}.
  - The default `ELEM_W` = 24.
- **Sub-modules.** None required. Byte selection is a mux on the index: element = (index−1)/BPE, using a counter pair (element, byte) instead of division. Keep it in-module.

## Test plan
- **Basic frame.** Elements 1..9, defaults; transmitter model raises `tx_done` 10 cycles after each `tx_start` → bytes A5, 00 00 01, 00 00 02, …, 00 00 09, then checksum 01. There are 29 `tx_start` pulses and `frame_done` follows the 29th `tx_done`.
- **Maximum element.** All elements 0x02FA03 → each element is sent as 02 FA 03. The checksum is 02^FA^03 = 0xFB (9 odd repeats).
- **Busy transmitter.** `tx_busy` held high for 50 cycles after load → no `tx_start` until `tx_busy` falls. Then the header is sent within 1 cycle.
- **Spurious inputs.**
  - `tx_done` pulsed in IDLE and in ISSUE → the byte index is unchanged and the frame is identical to the basic-frame case.
  - `load_valid` mid-frame with different data → ignored, and the original frame completes intact.
- **Reset mid-frame.** Assert `rst` after byte 10 → outputs go to reset values immediately. A new load of elements 1..9 then produces the full basic frame starting at A5.
- **`CHECKSUM_EN` = 0.** Elements 1..9 → a 28-byte frame with no trailing byte, and `frame_done` follows byte 28.
